// File: rtl/reg_pair_sequencer_if.sv
// Pushbutton, switch and display signals of the two-register sequencer.
// The master side drives the button and switches; the slave side is the sequencer.
interface reg_pair_sequencer_if;
  logic        Step;
  logic [15:0] SW;
  logic [1:0]  Op;
  logic        Chain;
  logic [15:0] reg_a;
  logic [15:0] reg_b;
  logic [2:0]  state;
  logic        busy;
  logic        carry;
  logic        zero;

  modport master (
    output Step, SW, Op, Chain,
    input  reg_a, reg_b, state, busy, carry, zero
  );

  modport slave (
    input  Step, SW, Op, Chain,
    output reg_a, reg_b, state, busy, carry, zero
  );
endinterface

// File: rtl/reg_pair_sequencer.sv
// Button-stepped sequencer: load A, load B, run one ALU op, write the result back into A.
// The raw pushbutton is synchronised, debounced and rising-edge detected here.
//
// state  | meaning
// WAIT_A | waiting for a step to load operand A from the switches
// WAIT_B | waiting for a step to load operand B and latch the op
// EXEC   | one-cycle execute; result, carry and zero are written
// DONE   | result shown in reg_a; step chains (Chain=1) or restarts
module reg_pair_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  reg_pair_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    WAIT_B = 3'd1,
    EXEC   = 3'd2,
    DONE   = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             step_pulse_q, step_pulse_d;
  logic             step_pulse;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_t           state_q, state_d;
  logic [15:0]      reg_a_q, reg_a_d;
  logic [15:0]      reg_b_q, reg_b_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic [16:0]      alu_res;

  // A new level is accepted only after it has been seen on consecutive samples.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign step_pulse_d = stable_q & ~stable_dly_q;
  assign step_pulse   = step_pulse_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      step_pulse_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= bus.Step;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      step_pulse_q <= step_pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  // Bit 16 is the ADD carry-out or, for SUB, the borrow (a < b).
  always_comb begin
    case (op_q)
      2'b00:   alu_res = {1'b0, reg_a_q ^ reg_b_q};
      2'b01:   alu_res = {1'b0, reg_a_q} + {1'b0, reg_b_q};
      2'b10:   alu_res = {1'b0, reg_a_q} - {1'b0, reg_b_q};
      default: alu_res = {1'b0, reg_a_q & reg_b_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    op_d    = op_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      WAIT_A: begin
        if (step_pulse) begin
          reg_a_d = bus.SW;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (step_pulse) begin
          reg_b_d = bus.SW;
          op_d    = bus.Op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        reg_a_d = alu_res[15:0];
        carry_d = alu_res[16];
        zero_d  = (alu_res[15:0] == 16'h0000);
        state_d = DONE;
      end
      DONE: begin
        if (step_pulse) begin
          state_d = bus.Chain ? WAIT_B : WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
    busy_d = (state_d == EXEC);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= WAIT_A;
      reg_a_q <= 16'h0000;
      reg_b_q <= 16'h0000;
      op_q    <= 2'b00;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.reg_a = reg_a_q;
  assign bus.reg_b = reg_b_q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Bench for reg_pair_sequencer with a short debounce window.
// Expected register contents come from an arithmetic model of the operand/op rules.
module tb_reg_pair_sequencer;
  localparam int DEB = 4;
  // Step rise -> FSM update: DEB+3 cycles to the pulse, plus the cycle it is consumed on.
  localparam int LAT = DEB + 4;

  logic Clock = 1'b0;
  logic Reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  reg_pair_sequencer_if bus_if ();

  reg_pair_sequencer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 Clock = ~Clock;

  int m_a, m_b, m_st;
  bit m_c, m_z;

  logic [36:0] obs, exp_v;
  assign obs   = {bus_if.reg_a, bus_if.reg_b, bus_if.carry, bus_if.zero, bus_if.state};
  assign exp_v = {16'(m_a), 16'(m_b), m_c, m_z, 3'(m_st)};

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_st = 0;
  endtask

  task automatic model_press(input int sw, input int op, input bit chain);
    int s;
    case (m_st)
      0: begin m_a = sw; m_st = 1; end
      1: begin
        m_b = sw;
        case (op)
          0: begin s = m_a ^ m_b; m_c = 0; end
          1: begin s = m_a + m_b; m_c = (s >= 65536); s = s % 65536; end
          2: begin s = m_a - m_b; m_c = (s < 0); s = (s + 65536) % 65536; end
          default: begin s = m_a & m_b; m_c = 0; end
        endcase
        m_a  = s;
        m_z  = (s == 0);
        m_st = 3;
      end
      default: m_st = chain ? 1 : 0;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Presses and releases the button; lat = edges from press to the state change.
  task automatic press(output int lat, output logic busy_exec, output logic busy_after);
    logic [2:0] st0;
    st0 = bus_if.state;
    lat = -1;
    busy_exec = 1'b0;
    busy_after = 1'b0;
    bus_if.Step = 1'b1;
    for (int i = 1; i <= LAT + 20; i++) begin
      tick(1);
      if (bus_if.state !== st0) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      tests_run++; tests_failed++;
      $display("FAIL press_timeout state=%0d did not change", bus_if.state);
    end else if (bus_if.state === 3'd2) begin
      busy_exec = bus_if.busy;
      tick(1);
      busy_after = bus_if.busy;
    end
    bus_if.Step = 1'b0;
    tick(DEB + 8);
  endtask

  task automatic do_press(input logic [15:0] sw, input logic [1:0] op, input logic chain);
    int lat;
    logic be, ba;
    bus_if.SW = sw; bus_if.Op = op; bus_if.Chain = chain;
    model_press(int'(sw), int'(op), chain);
    press(lat, be, ba);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus_if.Step = 1'b0; bus_if.SW = 16'h0; bus_if.Op = 2'b00; bus_if.Chain = 1'b0;
    model_reset();
    tick(3);
    Reset = 1'b0;
    tick(2);
    tests_run++;
    if ({obs, bus_if.busy} !== {37'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state got=%h busy=%b want=0", obs, bus_if.busy);
    end
  endtask

  task automatic test_xor();
    int lat;
    logic be, ba;
    do_press(16'h00FF, 2'b00, 1'b0);
    bus_if.SW = 16'h0F0F; bus_if.Op = 2'b00;
    model_press(16'h0F0F, 0, 1'b0);
    press(lat, be, ba);
    tests_run++;
    if ({be, ba} !== 2'b10) begin
      tests_failed++;
      $display("FAIL xor_busy got exec=%b after=%b want exec=1 after=0", be, ba);
    end
    tests_run++;
    if (obs !== {16'h0FF0, 16'h0F0F, 1'b0, 1'b0, 3'd3}) begin
      tests_failed++;
      $display("FAIL xor_result got=%h want=%h", obs, {16'h0FF0, 16'h0F0F, 1'b0, 1'b0, 3'd3});
    end
  endtask

  task automatic test_add_overflow();
    do_press(16'h0000, 2'b00, 1'b0);
    do_press(16'hFFFF, 2'b00, 1'b0);
    do_press(16'h0001, 2'b01, 1'b0);
    tests_run++;
    if ({bus_if.reg_a, bus_if.carry, bus_if.zero} !== {16'h0000, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL add_overflow got a=%h c=%b z=%b want a=0000 c=1 z=1",
               bus_if.reg_a, bus_if.carry, bus_if.zero);
    end
  endtask

  task automatic test_sub_chain();
    do_press(16'h0000, 2'b00, 1'b0);
    do_press(16'h0003, 2'b00, 1'b0);
    do_press(16'h0005, 2'b10, 1'b0);
    tests_run++;
    if ({bus_if.reg_a, bus_if.carry, bus_if.zero} !== {16'hFFFE, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL sub_borrow got a=%h c=%b z=%b want a=fffe c=1 z=0",
               bus_if.reg_a, bus_if.carry, bus_if.zero);
    end
    do_press(16'h1234, 2'b00, 1'b1);
    tests_run++;
    if ({bus_if.state, bus_if.reg_a} !== {3'd1, 16'hFFFE}) begin
      tests_failed++;
      $display("FAIL chain_state got st=%0d a=%h want st=1 a=fffe", bus_if.state, bus_if.reg_a);
    end
    do_press(16'h00FE, 2'b11, 1'b0);
    tests_run++;
    if ({bus_if.reg_a, bus_if.carry} !== {16'h00FE, 1'b0}) begin
      tests_failed++;
      $display("FAIL chain_and got a=%h c=%b want a=00fe c=0", bus_if.reg_a, bus_if.carry);
    end
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL chain_model got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_glitch();
    bus_if.SW = 16'hABCD; bus_if.Chain = 1'b0;
    bus_if.Step = 1'b1; tick(1);
    bus_if.Step = 1'b0; tick(1);
    bus_if.Step = 1'b1; tick(1);
    bus_if.Step = 1'b0;
    tick(30);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL glitch_ignored got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_hold_latency();
    int lat;
    lat = -1;
    bus_if.Chain = 1'b0;
    bus_if.Step = 1'b1;
    for (int i = 1; i <= LAT + 20; i++) begin
      tick(1);
      if (bus_if.state !== 3'd3) begin
        lat = i;
        break;
      end
    end
    model_press(0, 0, 1'b0);
    tests_run++;
    if (lat != LAT) begin
      tests_failed++;
      $display("FAIL hold_latency got=%0d want=%0d", lat, LAT);
    end
    tick(30);
    tests_run++;
    if (bus_if.state !== 3'd0) begin
      tests_failed++;
      $display("FAIL hold_single got state=%0d want=0", bus_if.state);
    end
    bus_if.Step = 1'b0;
    tick(30);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL release_no_pulse got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_exec_drop();
    bit seen;
    seen = 0;
    do_press(16'h1111, 2'b00, 1'b0);
    bus_if.SW = 16'h2222; bus_if.Op = 2'b01; bus_if.Chain = 1'b1;
    model_press(16'h2222, 1, 1'b0);
    bus_if.Step = 1'b1;
    for (int i = 1; i <= LAT + 20; i++) begin
      tick(1);
      if (bus_if.state === 3'd2) begin
        seen = 1;
        break;
      end
    end
    if (seen) begin
      force dut.step_pulse = 1'b1;
      tick(1);
      release dut.step_pulse;
    end
    tick(3);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL exec_drop got=%h want=%h", obs, exp_v);
    end
    bus_if.Step = 1'b0;
    tick(DEB + 8);
  endtask

  task automatic test_reset_in_exec();
    bit seen;
    seen = 0;
    do_press(16'h0000, 2'b00, 1'b0);
    do_press(16'hFFFF, 2'b00, 1'b0);
    bus_if.SW = 16'h0001; bus_if.Op = 2'b01;
    bus_if.Step = 1'b1;
    for (int i = 1; i <= LAT + 20; i++) begin
      tick(1);
      if (bus_if.state === 3'd2) begin
        seen = 1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL exec_reach got state=%0d want=2", bus_if.state);
    end
    Reset = 1'b1;
    bus_if.Step = 1'b0;
    model_reset();
    #2;
    tests_run++;
    if ({obs, bus_if.busy} !== {37'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_async got=%h busy=%b want=0", obs, bus_if.busy);
    end
    tick(1);
    Reset = 1'b0;
    tick(20);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_exec_after got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    logic [15:0] sw;
    logic [1:0]  op;
    logic        ch;
    for (int n = 0; n < 24; n++) begin
      sw = 16'($urandom);
      if (n % 5 == 0) sw = bus_if.reg_a;
      op = 2'($urandom_range(0, 3));
      ch = 1'($urandom_range(0, 1));
      do_press(sw, op, ch);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL random_%0d sw=%h op=%0d got=%h want=%h", n, sw, op, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_add_overflow();
    test_sub_chain();
    test_glitch();
    test_hold_latency();
    test_exec_drop();
    test_reset_in_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
